// File: rtl/gray2bin_seq.sv
// Sequential Gray-to-binary decoder: one bit per cycle, MSB first, with
// valid/ready handshakes and a saturating count of non-consecutive words.
module gray2bin_seq #(
  parameter int NUM = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NUM-1:0] g_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [NUM-1:0] b_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           step_err,
  output logic [7:0]     err_cnt
);

  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    DONE
  } state_t;

  state_t         state;
  logic [NUM-1:0] g_reg;
  logic [NUM-1:0] res;
  logic [NUM-1:0] res_next;
  logic [NUM-1:0] prev;
  logic [IW-1:0]  idx;
  logic           acc;
  logic           bit_next;
  logic           have_prev;

  // acc holds the previously resolved (more significant) binary bit
  always_comb begin
    bit_next      = acc ^ g_reg[idx];
    res_next      = res;
    res_next[idx] = bit_next;
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      b_out     <= '0;
      step_err  <= 1'b0;
      err_cnt   <= 8'd0;
      prev      <= '0;
      have_prev <= 1'b0;
      g_reg     <= '0;
      res       <= '0;
      idx       <= '0;
      acc       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            g_reg    <= g_in;
            res      <= '0;
            acc      <= 1'b0;
            idx      <= IW'(NUM - 1);
            in_ready <= 1'b0;
            state    <= DECODE;
          end
        end

        DECODE: begin
          res <= res_next;
          acc <= bit_next;
          if (idx == '0) begin
            b_out     <= res_next;
            // The adder width wraps 2^NUM-1 to 0, so wrap-around is a legal step
            step_err  <= have_prev && (res_next != prev + NUM'(1));
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            prev      <= b_out;
            have_prev <= 1'b1;
            if (step_err && (err_cnt != 8'hFF)) begin
              err_cnt <= err_cnt + 8'd1;
            end
            step_err  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          step_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray2bin_seq.sv
// Bench for gray2bin_seq: a transaction-level reference model compared every
// cycle, plus directed words with hand-computed results.
module tb_gray2bin_seq;

  localparam int NUM = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NUM-1:0] g_in = '0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           in_ready;
  logic [NUM-1:0] b_out;
  logic           out_valid;
  logic           step_err;
  logic [7:0]     err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gray2bin_seq #(.NUM(NUM)) dut (
    .clk       (clk),
    .reset     (reset),
    .g_in      (g_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .b_out     (b_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: binary bit i is the parity of all Gray bits at or above i
  function automatic logic [NUM-1:0] g2b(input logic [NUM-1:0] g);
    logic [NUM-1:0] b;
    for (int i = 0; i < NUM; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic           m_rdy = 1'b1;
  logic           m_ov = 1'b0;
  logic           m_se = 1'b0;
  logic           m_hp = 1'b0;
  logic [NUM-1:0] m_b = '0;
  logic [NUM-1:0] m_g = '0;
  logic [NUM-1:0] m_prev = '0;
  int             m_cnt = 0;
  int             m_left = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rdy = 1'b1; m_ov = 1'b0; m_se = 1'b0; m_hp = 1'b0;
      m_b = '0; m_prev = '0; m_cnt = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_b  = g2b(m_g);
        m_se = m_hp && (int'(m_b) != (int'(m_prev) + 1) % (1 << NUM));
        m_ov = 1'b1;
      end
    end else if (m_rdy && in_valid) begin
      m_g    = g_in;
      m_rdy  = 1'b0;
      m_left = NUM;
    end else if (m_ov && out_ready) begin
      m_ov   = 1'b0;
      m_prev = m_b;
      m_hp   = 1'b1;
      if (m_se && m_cnt < 255) m_cnt++;
      m_se   = 1'b0;
      m_rdy  = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_rdy);
    check("out_valid", out_valid, m_ov);
    check("b_out", b_out, m_b);
    check("step_err", step_err, m_se);
    check("err_cnt", err_cnt, m_cnt);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Present g until it is captured; afterwards g_in is scrambled
  task automatic capture(input logic [NUM-1:0] g);
    int n = 0;
    g_in = g;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("capture_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    g_in = ~g;
  endtask

  task automatic finish_word(input int hold, output logic [NUM-1:0] b, output logic se);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
      g_in = g_in ^ NUM'(1);
    end
    check("latency", n, 6);
    b = b_out;
    se = step_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      g_in = ~g_in;
      check("bp_b_out", b_out, b);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
  endtask

  task automatic word(input logic [NUM-1:0] g, input int hold,
                      output logic [NUM-1:0] b, output logic se);
    capture(g);
    finish_word(hold, b, se);
  endtask

  initial begin
    logic [NUM-1:0] b;
    logic           se;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_b_out", b_out, 0);
    check("rst_step_err", step_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    reset = 1'b0;

    // Single words, the second one held under backpressure
    word(6'b110101, 0, b, se);
    check("single_b", b, 6'b100110);
    check("single_se", se, 0);
    word(6'b100000, 3, b, se);
    check("msb_only_b", b, 6'b111111);

    // Full sweep in counting order
    do_reset();
    for (int i = 0; i < 64; i++) begin
      word(NUM'(i ^ (i >> 1)), 0, b, se);
      check("sweep_b", b, i);
      check("sweep_se", se, 0);
    end
    check("sweep_err_cnt", err_cnt, 0);

    // Skip detection: 5 then 7
    do_reset();
    word(6'b000111, 0, b, se);
    check("skip_first_b", b, 6'b000101);
    check("skip_first_se", se, 0);
    word(6'b000100, 0, b, se);
    check("skip_b", b, 6'b000111);
    check("skip_se", se, 1);
    check("skip_err_cnt", err_cnt, 1);

    // Reset in the middle of a decode
    capture(6'b001010);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    word(6'b000001, 0, b, se);
    check("post_rst_b", b, 6'b000001);
    check("post_rst_se", se, 0);

    // Wrap-around 63 -> 0
    do_reset();
    word(6'b100000, 0, b, se);
    check("wrap_first_b", b, 6'b111111);
    word(6'b000000, 0, b, se);
    check("wrap_b", b, 6'b000000);
    check("wrap_se", se, 0);
    check("wrap_err_cnt", err_cnt, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
